// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the fetch/load-store memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  // Only the low three address bits matter for natural alignment up to 8 bytes.
  function automatic logic is_aligned(input logic [2:0] addr, input logic [1:0] size);
    logic ok;
    ok = 1'b1;
    case (size)
      SZ_B:    ok = 1'b1;
      SZ_H:    ok = (addr[0] == 1'b0);
      SZ_W:    ok = (addr[1:0] == 2'b00);
      SZ_D:    ok = (addr == 3'b000);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin chooser: on collision, picks the port that did not win last.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic pick,
  output logic any
);

  assign any  = req0 | req1;
  assign pick = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (port 0) and load/store (port 1),
// with alignment checking and a fixed wait-state count per access.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW          = 64,
  parameter int DW          = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic          we0,
  input  logic [DW-1:0] wdata0,
  input  logic [1:0]    size0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  input  logic          we1,
  input  logic [DW-1:0] wdata1,
  input  logic [1:0]    size1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          err0,
  output logic          err1,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wd,
  output logic [1:0]    mem_size,
  input  logic [DW-1:0] mem_rd
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_t          state, state_nxt;
  logic            last_gnt;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   addr_q;
  logic            we_q;
  logic [DW-1:0]   wd_q;
  logic [1:0]      size_q;
  logic            port_q;
  logic            err_q;
  logic [DW-1:0]   rdata_q;

  logic            pick, any, grant;
  logic [AW-1:0]   sel_addr;
  logic            sel_we;
  logic [DW-1:0]   sel_wd;
  logic [1:0]      sel_size;
  logic            sel_ok;

  rr_pick2 u_pick (
    .req0 (req0),
    .req1 (req1),
    .last (last_gnt),
    .pick (pick),
    .any  (any)
  );

  assign sel_addr = pick ? addr1  : addr0;
  assign sel_we   = pick ? we1    : we0;
  assign sel_wd   = pick ? wdata1 : wdata0;
  assign sel_size = pick ? size1  : size0;
  assign sel_ok   = is_aligned(sel_addr[2:0], sel_size);
  assign grant    = (state == IDLE) && any;

  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    rvalid0   = 1'b0;
    rvalid1   = 1'b0;
    rdata0    = '0;
    rdata1    = '0;
    err0      = 1'b0;
    err1      = 1'b0;
    mem_we    = 1'b0;
    case (state)
      IDLE: begin
        if (grant) begin
          gnt0      = ~pick;
          gnt1      = pick;
          state_nxt = sel_ok ? ACCESS : RESP;
        end
      end
      ACCESS: begin
        // Single write strobe, placed in the last wait cycle.
        mem_we = we_q && (cnt == '0);
        if (cnt == '0) state_nxt = RESP;
      end
      RESP: begin
        rvalid0   = ~port_q;
        rvalid1   = port_q;
        rdata0    = port_q ? '0 : rdata_q;
        rdata1    = port_q ? rdata_q : '0;
        err0      = ~port_q & err_q;
        err1      = port_q & err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last_gnt <= 1'b0;
      cnt      <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wd_q     <= '0;
      size_q   <= '0;
      port_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant) begin
            addr_q   <= sel_addr;
            we_q     <= sel_we;
            wd_q     <= sel_wd;
            size_q   <= sel_size;
            port_q   <= pick;
            last_gnt <= pick;
            err_q    <= ~sel_ok;
            rdata_q  <= '0;
            cnt      <= sel_ok ? CW'(WAIT_CYCLES - 1) : '0;
          end
        end
        ACCESS: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
          else           rdata_q <= we_q ? '0 : mem_rd;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign mem_addr = addr_q;
  assign mem_wd   = wd_q;
  assign mem_size = size_q;

endmodule
